microwave_ctrl: RTL
===================

# microwave_ctrl

Cook-time entry and countdown controller for the microwave. Consumes digits from the keypad encoder (D, loadn), builds an MM:SS cook time, counts it down on a 1 Hz strobe while the magnetron is on, and handles start, stop/clear and door interlock. It drives the encoder's enablen to lock the keypad while a cook cycle is active or paused.

## Interface
- Parameters: none. Digit width is fixed at 4-bit BCD; the format is fixed at MM:SS, with a maximum of 99:59.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- D  in  4  BCD key code from encoder; valid while loadn=0
- loadn  in  1  encoder key strobe, active-low level
- tick_1hz  in  1  one-cycle strobe, once per second, synchronous to clk
- start  in  1  one-cycle start strobe, debounced
- stop  in  1  one-cycle stop/clear strobe, debounced
- door_closed  in  1  door interlock level; 1 = closed
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  displayed/remaining time, BCD
- mag_on  out  1  magnetron enable
- enablen  out  1  to encoder; 1 = keypad disabled
- done  out  1  cook complete indicator

## Operation
- **Reset values:** all digits 0, mag_on=0, enablen=0, done=0, state IDLE.
- **Key acceptance:** a key is accepted on the cycle where loadn goes 1→0. loadn is registered, and acceptance occurs on the falling edge of the registered copy. Holding loadn low yields exactly one key.
- **Ignored keys:** D values >9 are ignored. A key is also ignored when sec_ones >5, because the shift would make sec_tens >5.
- **Digit shift on accepted key:** min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←D. The old min_tens is discarded. Keys are accepted only in IDLE, ENTRY and DONE.
- **States:**
  - IDLE: all outputs at reset values.
    - key → ENTRY, with the shift applied.
    - start with time 00:00 is ignored.
  - ENTRY: enablen=0.
    - stop → digits cleared, IDLE.
    - start with door_closed=1 and time≠00:00 → COOK.
    - start with the door open → stay in ENTRY.
  - COOK: mag_on=1, enablen=1; keys ignored.
    - tick_1hz decrements the time by one second. BCD borrow: sec_ones 0→9 borrows from sec_tens; sec_tens 0→5 borrows from min_ones; min_ones 0→9 borrows from min_tens.
    - A tick at 00:01 produces 00:00 and → DONE.
    - door_closed=0 or stop → PAUSE.
  - PAUSE: mag_on=0, enablen=1, time held.
    - stop → digits cleared, IDLE.
    - start with door_closed=1 → COOK.
  - DONE: done=1, mag_on=0, enablen=0, digits 00:00.
    - stop, an accepted key, or door_closed 1→0 → IDLE (done=0). An accepted key is also shifted in and goes to ENTRY.
- **Priority (same cycle):** rst > stop > door open > start > tick > key.
  - stop with start: stop wins.
  - Door opening with a tick in COOK: no decrement; → PAUSE.
  - start with a tick in ENTRY/PAUSE: no decrement that cycle.

## Timing
- All outputs are registered. mag_on rises 1 cycle after the start strobe is sampled, and falls 1 cycle after door_closed=0 or stop is sampled.
- A digit update is visible 2 cycles after loadn falls: 1 cycle for the loadn register, 1 cycle for the shift.
- A decrement is visible 1 cycle after tick_1hz. DONE/done assert in the same cycle the digits reach 00:00.
- rst asserted mid-cook forces mag_on=0 and clears the time at the next edge. No pending state survives reset.

## Structure
- **microwave_pkg:**
  - State encoding: IDLE, ENTRY, COOK, PAUSE, DONE.
  - BCD constants: DIGIT_MAX=9, SEC_TENS_MAX=5.
  - Key-valid limit.
- **Sub-module bcd_time_counter:** 4-digit MM:SS register with these operations:
  - shift-in
  - clear
  - decrement with borrow
  - is_zero flag
- microwave_ctrl holds the FSM, the loadn edge detect, and output decode.

## Test plan
- Enter keys 1,3,0 via loadn pulses → display 01:30. start with door closed → mag_on=1 next cycle. 90 ticks → 00:00, done=1, mag_on=0.
- From 01:00, one tick → 00:59. From 10:00, one tick → 09:59 (multi-digit borrow).
- During COOK at 00:45, drop door_closed → PAUSE, mag_on=0. Ticks are ignored and 00:45 holds. Door closes, then start → COOK resumes from 00:45.
- Key 7 then key 2 → 00:07, then 00:72 is rejected and 00:07 holds. A 5-key entry 1,2,3,4,5 → 23:45. Holding loadn low 10 cycles adds one digit only.
- start and stop in the same cycle from ENTRY at 00:30 → IDLE, 00:00, mag_on=0. start at 00:00 → stays IDLE.
- rst asserted mid-COOK at 02:10 → next edge: all digits 0, mag_on=0, enablen=0, done=0.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cook-time controller.
// Holds the controller state encoding, the counter operation codes,
// the BCD digit limits and the key-validity check used on keypad entry.
package microwave_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Operations the time counter can perform on a given clock edge.
  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_CLEAR = 2'd2,
    OP_DEC   = 2'd3
  } cnt_op_t;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] KEY_MAX      = 4'd9;

  // A key is usable only if it is a decimal digit and the current
  // seconds-ones digit can legally move into the seconds-tens slot.
  function automatic logic keyIsValid(input logic [3:0] d, input logic [3:0] secOnes);
    return (d <= KEY_MAX) && (secOnes <= SEC_TENS_MAX);
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Four-digit MM:SS BCD time register.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   op_i            operation for this edge: none, shift-in, clear, decrement
//   digit_i         BCD digit shifted into the seconds-ones position
//   min_tens_o ..   current time digits
//   sec_ones_o
//   is_zero_o       high when the time reads 00:00
module bcd_time_counter
  import microwave_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  cnt_op_t    op_i,
  input  logic [3:0] digit_i,
  output logic [3:0] min_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] sec_ones_o,
  output logic       is_zero_o
);

  logic [3:0] minTens_q, minOnes_q, secTens_q, secOnes_q;
  logic [3:0] minTens_d, minOnes_d, secTens_d, secOnes_d;
  logic       isZero;

  assign isZero = (minTens_q == 4'd0) && (minOnes_q == 4'd0) &&
                  (secTens_q == 4'd0) && (secOnes_q == 4'd0);

  // Next-time computation. Decrement ripples a borrow from the seconds
  // digits up to the minute tens; seconds-tens wraps to 5, the others to 9.
  // A decrement at 00:00 is suppressed so the time can never wrap to 99:59.
  always_comb begin
    minTens_d = minTens_q;
    minOnes_d = minOnes_q;
    secTens_d = secTens_q;
    secOnes_d = secOnes_q;
    case (op_i)
      OP_CLEAR: begin
        minTens_d = 4'd0;
        minOnes_d = 4'd0;
        secTens_d = 4'd0;
        secOnes_d = 4'd0;
      end
      OP_SHIFT: begin
        minTens_d = minOnes_q;
        minOnes_d = secTens_q;
        secTens_d = secOnes_q;
        secOnes_d = digit_i;
      end
      OP_DEC: begin
        if (!isZero) begin
          if (secOnes_q != 4'd0) begin
            secOnes_d = secOnes_q - 4'd1;
          end else begin
            secOnes_d = DIGIT_MAX;
            if (secTens_q != 4'd0) begin
              secTens_d = secTens_q - 4'd1;
            end else begin
              secTens_d = SEC_TENS_MAX;
              if (minOnes_q != 4'd0) begin
                minOnes_d = minOnes_q - 4'd1;
              end else begin
                minOnes_d = DIGIT_MAX;
                minTens_d = minTens_q - 4'd1;
              end
            end
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Digit storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      minTens_q <= 4'd0;
      minOnes_q <= 4'd0;
      secTens_q <= 4'd0;
      secOnes_q <= 4'd0;
    end else begin
      minTens_q <= minTens_d;
      minOnes_q <= minOnes_d;
      secTens_q <= secTens_d;
      secOnes_q <= secOnes_d;
    end
  end

  assign min_tens_o = minTens_q;
  assign min_ones_o = minOnes_q;
  assign sec_tens_o = secTens_q;
  assign sec_ones_o = secOnes_q;
  assign is_zero_o  = isZero;

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave cook-time entry and countdown controller.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   D, loadn          keypad digit and active-low key strobe from the encoder
//   tick_1hz          one-cycle strobe per second
//   start, stop       one-cycle debounced button strobes
//   door_closed       door interlock level, 1 = closed
//   min_tens..sec_ones remaining/displayed time in BCD
//   mag_on            magnetron enable
//   enablen           keypad lock to the encoder, 1 = locked
//   done              cook-complete indicator
module microwave_ctrl
  import microwave_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       enablen,
  output logic       done
);

  state_t     state_q, state_d;
  cnt_op_t    cntOp;
  logic       loadn_q, loadnDly_q;
  logic [3:0] d_q;
  logic       doorPrev_q;
  logic       magOn_q, enablen_q, done_q;
  logic       isZero, atOne, keyEdge, keyAccept, doorFall;

  // Input capture: loadn and D are registered together so the digit stays
  // attached to its strobe; a second loadn stage gives the falling edge, so
  // holding the key down produces exactly one accepted key. The door level
  // is kept one cycle back to spot it opening while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      loadn_q    <= 1'b1;
      loadnDly_q <= 1'b1;
      d_q        <= 4'd0;
      doorPrev_q <= 1'b0;
    end else begin
      loadn_q    <= loadn;
      loadnDly_q <= loadn_q;
      d_q        <= D;
      doorPrev_q <= door_closed;
    end
  end

  assign keyEdge   = loadnDly_q & ~loadn_q;
  assign keyAccept = keyEdge && keyIsValid(d_q, sec_ones);
  assign doorFall  = doorPrev_q & ~door_closed;
  assign atOne     = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                     (sec_tens == 4'd0) && (sec_ones == 4'd1);

  bcd_time_counter u_time (
    .clk        (clk),
    .rst        (rst),
    .op_i       (cntOp),
    .digit_i    (d_q),
    .min_tens_o (min_tens),
    .min_ones_o (min_ones),
    .sec_tens_o (sec_tens),
    .sec_ones_o (sec_ones),
    .is_zero_o  (isZero)
  );

  // Next-state and counter-operation decode. Within each state the events
  // are tested in the order stop, door open, start, tick, key, so a
  // higher-priority event in the same cycle masks the lower ones.
  always_comb begin
    state_d = state_q;
    cntOp   = OP_NONE;
    case (state_q)
      IDLE: begin
        if (stop) begin
          cntOp = OP_CLEAR;
        end else if (keyAccept && !start) begin
          cntOp   = OP_SHIFT;
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (stop) begin
          cntOp   = OP_CLEAR;
          state_d = IDLE;
        end else if (start) begin
          if (door_closed && !isZero) begin
            state_d = COOK;
          end
        end else if (keyAccept) begin
          cntOp = OP_SHIFT;
        end
      end
      COOK: begin
        if (stop || !door_closed) begin
          state_d = PAUSE;
        end else if (tick_1hz) begin
          cntOp = OP_DEC;
          if (atOne) begin
            state_d = DONE;
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          cntOp   = OP_CLEAR;
          state_d = IDLE;
        end else if (start && door_closed) begin
          state_d = COOK;
        end
      end
      DONE: begin
        if (stop || doorFall) begin
          cntOp   = OP_CLEAR;
          state_d = IDLE;
        end else if (keyAccept && !start) begin
          cntOp   = OP_SHIFT;
          state_d = ENTRY;
        end
      end
      default: begin
        cntOp   = OP_CLEAR;
        state_d = IDLE;
      end
    endcase
  end

  // State register plus registered outputs decoded from the next state, so
  // the outputs change on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      magOn_q   <= 1'b0;
      enablen_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      magOn_q   <= (state_d == COOK);
      enablen_q <= (state_d == COOK) || (state_d == PAUSE);
      done_q    <= (state_d == DONE);
    end
  end

  assign mag_on  = magOn_q;
  assign enablen = enablen_q;
  assign done    = done_q;

endmodule
